video_frame_decoder: RTL

Receive-side counterpart to the video generators: consumes a composite `hsync`/`vsync`/`rgb` stream produced by `hvsync_generator`-based designs and recovers the beam position. It locks to the sync timing and reports per-frame lock status. It also tracks the bounding box of all pixels of a target colour, e.g. the white ball of a slip-counter game. It sits beside a generator in test harnesses and in self-checking demos that read back the picture.

---
 rtl/video_frame_decoder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/video_frame_decoder.sv
// video_frame_decoder: recovers beam position from a composite hsync/vsync/rgb
// stream, verifies sync timing to report lock, and tracks the bounding box of
// pixels matching TARGET_RGB once per frame.
// Optional feature macro: TRACKER_SIZE_EN adds obj_w/obj_h box-size outputs.
module video_frame_decoder #(
  parameter int unsigned H_DISPLAY    = 256,
  parameter int unsigned H_SYNC_START = 263,
  parameter int unsigned H_TOTAL      = 309,
  parameter int unsigned V_DISPLAY    = 240,
  parameter int unsigned V_SYNC_START = 254,
  parameter int unsigned V_TOTAL      = 262,
  parameter int unsigned LOCK_FRAMES  = 2,
  parameter logic [2:0]  TARGET_RGB   = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb,
  output logic [8:0] hpos,
  output logic [8:0] vpos,
  output logic       display_on,
  output logic       locked,
  output logic       frame_done,
  output logic       obj_found,
  output logic [8:0] obj_x,
  output logic [8:0] obj_y
`ifdef TRACKER_SIZE_EN
  ,
  output logic [8:0] obj_w,
  output logic [8:0] obj_h
`endif
);

  localparam logic [8:0] HD   = 9'(H_DISPLAY);
  localparam logic [8:0] HS   = 9'(H_SYNC_START);
  localparam logic [8:0] HS1  = 9'(H_SYNC_START + 1);
  localparam logic [8:0] HT1  = 9'(H_TOTAL - 1);
  localparam logic [8:0] VD   = 9'(V_DISPLAY);
  localparam logic [8:0] VS   = 9'(V_SYNC_START);
  localparam logic [8:0] VT1  = 9'(V_TOTAL - 1);
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_FRAMES);

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_e;

  logic       hsync_q, hsync_qq, vsync_q, vsync_qq;
  logic [2:0] rgb_q;
  logic [8:0] hpos_q, hpos_d, vpos_q, vpos_d;
  state_e     state_q;
  logic [3:0] good_cnt_q;
  logic       locked_q;
  logic [8:0] min_x_q, min_y_q;
  logic       seen_q;
  logic       obj_found_q;
  logic [8:0] obj_x_q, obj_y_q;
`ifdef TRACKER_SIZE_EN
  logic [8:0] max_x_q, max_y_q;
  logic [8:0] obj_w_q, obj_h_q;
`endif

  logic h_rise, v_rise, h_at, v_at;
  logic h_err, v_err, sync_err, v_good;
  logic disp, frame_end, target_hit;

  assign h_rise     = hsync_q & ~hsync_qq;
  assign v_rise     = vsync_q & ~vsync_qq;
  assign h_at       = (hpos_q == HS);
  assign v_at       = (hpos_q == '0) && (vpos_q == VS);
  assign h_err      = h_rise ^ h_at;
  assign v_err      = v_rise ^ v_at;
  assign sync_err   = h_err | v_err;
  assign v_good     = v_rise & v_at;
  assign disp       = locked_q && (hpos_q < HD) && (vpos_q < VD);
  assign frame_end  = locked_q && (hpos_q == '0) && (vpos_q == VD);
  assign target_hit = disp && (rgb_q == TARGET_RGB);

  // Input registers and sync edge-detect stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q  <= 1'b0;
      hsync_qq <= 1'b0;
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hsync_q  <= hsync;
      hsync_qq <= hsync_q;
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      rgb_q    <= rgb;
    end
  end

  // Next beam position: free-run with realignment on misplaced sync edges
  always_comb begin
    hpos_d = (hpos_q == HT1) ? '0 : hpos_q + 9'd1;
    vpos_d = vpos_q;
    if (hpos_q == HT1)
      vpos_d = (vpos_q == VT1) ? '0 : vpos_q + 9'd1;
    // A misplaced hsync edge pins hpos without a line wrap.
    if (h_rise && !h_at) begin
      hpos_d = HS1;
      vpos_d = vpos_q;
    end
    if (v_rise && !v_at)
      vpos_d = VS;
  end

  // Beam position registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpos_q <= '0;
      vpos_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  // Lock FSM: count consecutive clean frames, drop lock on any sync error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SEARCH;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (sync_err) begin
            good_cnt_q <= '0;
          end else if (v_good) begin
            if (good_cnt_q + 4'd1 == LOCK_CNT) begin
              state_q    <= ST_LOCKED;
              locked_q   <= 1'b1;
              good_cnt_q <= '0;
            end else begin
              good_cnt_q <= good_cnt_q + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (sync_err) begin
            state_q    <= ST_SEARCH;
            locked_q   <= 1'b0;
            good_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= ST_SEARCH;
          locked_q   <= 1'b0;
          good_cnt_q <= '0;
        end
      endcase
    end
  end

  // Running bounding box of target pixels within the current frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_x_q <= '1;
      min_y_q <= '1;
      seen_q  <= 1'b0;
`ifdef TRACKER_SIZE_EN
      max_x_q <= '0;
      max_y_q <= '0;
`endif
    end else if (!locked_q || frame_end) begin
      min_x_q <= '1;
      min_y_q <= '1;
      seen_q  <= 1'b0;
`ifdef TRACKER_SIZE_EN
      max_x_q <= '0;
      max_y_q <= '0;
`endif
    end else if (target_hit) begin
      seen_q <= 1'b1;
      if (hpos_q < min_x_q) min_x_q <= hpos_q;
      if (vpos_q < min_y_q) min_y_q <= vpos_q;
`ifdef TRACKER_SIZE_EN
      if (hpos_q > max_x_q) max_x_q <= hpos_q;
      if (vpos_q > max_y_q) max_y_q <= vpos_q;
`endif
    end
  end

  // Publish the finished frame's box at frame end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      obj_found_q <= 1'b0;
      obj_x_q     <= '0;
      obj_y_q     <= '0;
`ifdef TRACKER_SIZE_EN
      obj_w_q     <= '0;
      obj_h_q     <= '0;
`endif
    end else if (frame_end) begin
      obj_found_q <= seen_q;
      if (seen_q) begin
        obj_x_q <= min_x_q;
        obj_y_q <= min_y_q;
`ifdef TRACKER_SIZE_EN
        obj_w_q <= max_x_q - min_x_q + 9'd1;
        obj_h_q <= max_y_q - min_y_q + 9'd1;
`endif
      end
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign display_on = disp;
  assign locked     = locked_q;
  assign frame_done = frame_end;
  assign obj_found  = obj_found_q;
  assign obj_x      = obj_x_q;
  assign obj_y      = obj_y_q;
`ifdef TRACKER_SIZE_EN
  assign obj_w      = obj_w_q;
  assign obj_h      = obj_h_q;
`endif

endmodule
